fib_ctrl: RTL and testbench

Synchronous sequencer for the asynchronous dual-rail Fibonacci ring (`fib`). Owns the ring's reset and start/inject enable, consumes ring output tokens with a four-phase return-to-zero handshake on the ring's `ack_i`, decodes each dual-rail word to binary, and presents it to clocked logic on a valid/ready port. A host command requests N terms; the block sequences ring reset, injection, N token handshakes, then returns the ring to reset.

---
 rtl/fib_ctrl_pkg.sv | 24 ++
 rtl/dual_rail_sync_detect.sv | 81 ++++++++
 rtl/fib_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fib_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_ctrl_pkg.sv
// rtl/fib_ctrl_pkg.sv - shared types for the Fibonacci ring sequencer
package fib_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_DATA,
        CAPTURE,
        WAIT_NULL,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        NULL,
        VALID,
        PARTIAL,
        ILLEGAL
    } word_class_t;

    // Rail 0 high encodes logic 0, rail 1 high encodes logic 1.
    localparam int RAIL_F = 0;
    localparam int RAIL_T = 1;

endpackage

// File: rtl/dual_rail_sync_detect.sv
// rtl/dual_rail_sync_detect.sv - synchronise, classify and decode a dual-rail word
module dual_rail_sync_detect
    import fib_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0][1:0]  ring_out,
    output logic                   seen_valid,
    output logic                   seen_null,
    output logic                   seen_illegal,
    output logic [WIDTH-1:0]       data
);

    logic [WIDTH-1:0][1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0][1:0] cur_word;
    logic [WIDTH-1:0][1:0] prev_word;
    word_class_t           cur_class;
    word_class_t           prev_class;

    function automatic word_class_t classify(input logic [WIDTH-1:0][1:0] w);
        logic any_both;
        logic all_one_hot;
        logic any_high;
        any_both    = 1'b0;
        all_one_hot = 1'b1;
        any_high    = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            any_both    = any_both | (w[k][RAIL_F] & w[k][RAIL_T]);
            all_one_hot = all_one_hot & (w[k][RAIL_F] ^ w[k][RAIL_T]);
            any_high    = any_high | w[k][RAIL_F] | w[k][RAIL_T];
        end
        if (any_both) begin
            return ILLEGAL;
        end
        if (!any_high) begin
            return NULL;
        end
        if (all_one_hot) begin
            return VALID;
        end
        return PARTIAL;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ring_out;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // The last two chain stages are consecutive samples, so a stable word is
    // recognised the cycle it emerges from the synchroniser.
    assign cur_word  = sync_q[SYNC_STAGES-1];
    assign prev_word = sync_q[SYNC_STAGES-2];

    always_comb begin
        cur_class  = classify(cur_word);
        prev_class = classify(prev_word);
    end

    assign seen_valid   = (cur_class == VALID) && (prev_class == VALID) && (cur_word == prev_word);
    assign seen_null    = (cur_class == NULL) && (prev_class == NULL);
    assign seen_illegal = (cur_class == ILLEGAL) && (prev_class == ILLEGAL);

    always_comb begin
        data = '0;
        for (int k = 0; k < WIDTH; k++) begin
            data[k] = cur_word[k][RAIL_T];
        end
    end

endmodule

// File: rtl/fib_ctrl.sv
// rtl/fib_ctrl.sv - sequencer that runs the dual-rail Fibonacci ring for N terms
module fib_ctrl
    import fib_ctrl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RST_CYC     = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [CNT_W-1:0]       cmd_count,
    input  logic                   abort,
    output logic                   ring_rst,
    output logic                   ring_start,
    output logic                   ring_ack,
    input  logic [WIDTH-1:0][1:0]  ring_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_last,
    output logic                   res_ovf,
    output logic                   busy,
    output logic                   done,
    output logic                   err_proto,
    output logic                   err_timeout
);

    localparam int DW = $clog2(RST_CYC + 2);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            next_state;
    logic              seen_valid;
    logic              seen_null;
    logic              seen_illegal;
    logic [WIDTH-1:0]  ring_data;
    logic [DW-1:0]     dwell_q;
    logic [TW-1:0]     tmo_q;
    logic [CNT_W-1:0]  remain_q;
    logic [WIDTH-1:0]  prev_q;
    logic              first_q;
    logic              zero_done_q;
    logic              accept;
    logic              timed_state;
    logic              tmo_hit;
    logic              abort_path;
    logic              out_free;
    logic              capture;

    dual_rail_sync_detect #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_detect (
        .clk          (clk),
        .rst          (rst),
        .ring_out     (ring_out),
        .seen_valid   (seen_valid),
        .seen_null    (seen_null),
        .seen_illegal (seen_illegal),
        .data         (ring_data)
    );

    assign accept      = cmd_ready && cmd_valid;
    assign timed_state = (state == ARM) || (state == WAIT_DATA) || (state == WAIT_NULL);
    assign tmo_hit     = timed_state && (tmo_q == TW'(TIMEOUT - 1));
    assign abort_path  = (state != IDLE) && (abort || seen_illegal || tmo_hit);
    assign out_free    = !res_valid || res_ready;
    assign capture     = (state == CAPTURE) && !abort_path;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && (cmd_count != '0)) begin
                    next_state = ARM;
                end
            end
            ARM, WAIT_DATA: begin
                if (seen_valid) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = WAIT_NULL;
            end
            WAIT_NULL: begin
                // Holding here keeps ring_ack high, which stalls the ring under backpressure.
                if (seen_null && out_free) begin
                    next_state = (remain_q == '0) ? DONE : WAIT_DATA;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (abort_path) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        ring_rst   = (state == IDLE);
        ring_start = (state == ARM);
        ring_ack   = (state == WAIT_NULL);
        busy       = (state != IDLE);
        done       = (state == DONE) || zero_done_q;
        cmd_ready  = (state == IDLE) && (dwell_q == DW'(RST_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst || (state != IDLE)) begin
            dwell_q <= '0;
        end else if (dwell_q != DW'(RST_CYC)) begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !timed_state || (next_state != state)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q    <= '0;
            prev_q      <= '0;
            first_q     <= 1'b0;
            zero_done_q <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_last    <= 1'b0;
            res_ovf     <= 1'b0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            zero_done_q <= accept && (cmd_count == '0);
            if (accept) begin
                remain_q    <= cmd_count;
                first_q     <= 1'b1;
                res_ovf     <= 1'b0;
                err_proto   <= 1'b0;
                err_timeout <= 1'b0;
            end
            if ((state != IDLE) && seen_illegal) begin
                err_proto <= 1'b1;
            end
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end
            if (abort_path) begin
                res_valid <= 1'b0;
            end else if (capture) begin
                res_valid <= 1'b1;
                res_data  <= ring_data;
                res_last  <= (remain_q == CNT_W'(1));
                remain_q  <= remain_q - CNT_W'(1);
                prev_q    <= ring_data;
                first_q   <= 1'b0;
                // A term smaller than its predecessor means the sum wrapped.
                if (!first_q && (ring_data < prev_q)) begin
                    res_ovf <= 1'b1;
                end
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fib_ctrl.sv
// tb/tb_fib_ctrl.sv - self-checking bench for fib_ctrl with a behavioural ring model
module tb_fib_ctrl;

    localparam int W  = 8;
    localparam int CW = 16;
    localparam int SS = 2;
    localparam int RC = 4;
    localparam int TO = 1024;

    logic                clk = 1'b0;
    logic                rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CW-1:0]       cmd_count;
    logic                abort;
    logic                ring_rst;
    logic                ring_start;
    logic                ring_ack;
    logic [W-1:0][1:0]   ring_out;
    logic                res_valid;
    logic                res_ready;
    logic [W-1:0]        res_data;
    logic                res_last;
    logic                res_ovf;
    logic                busy;
    logic                done;
    logic                err_proto;
    logic                err_timeout;

    always #5 clk = ~clk;

    fib_ctrl #(
        .WIDTH       (W),
        .CNT_W       (CW),
        .SYNC_STAGES (SS),
        .RST_CYC     (RC),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_count   (cmd_count),
        .abort       (abort),
        .ring_rst    (ring_rst),
        .ring_start  (ring_start),
        .ring_ack    (ring_ack),
        .ring_out    (ring_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last),
        .res_ovf     (res_ovf),
        .busy        (busy),
        .done        (done),
        .err_proto   (err_proto),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    int   ring_max_dly = 0;
    bit   stall_null = 1'b0;
    bit   inject_illegal = 1'b0;
    int   t_present = 0;
    int   present_idx = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] fib_term(input int i);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] t;
        a = 1;
        b = 1;
        for (int k = 0; k < i; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [W-1:0][1:0] encode(input logic [W-1:0] v);
        logic [W-1:0][1:0] w;
        for (int k = 0; k < W; k++) begin
            w[k][1] = v[k];
            w[k][0] = ~v[k];
        end
        return w;
    endfunction

    task automatic push_expect(input int n);
        bit ovf;
        exp_t e;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && fib_term(i) < fib_term(i - 1)) begin
                ovf = 1'b1;
            end
            e.data = fib_term(i);
            e.last = (i == n - 1);
            e.ovf  = ovf;
            exp_q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Ring model: emits the Fibonacci sequence under a four-phase handshake.
    initial begin
        int  phase;
        int  dly;
        int  idx;
        bit  started;
        phase = 0;
        dly = 0;
        idx = 0;
        started = 1'b0;
        ring_out = '0;
        forever begin
            @(negedge clk);
            if (ring_rst) begin
                ring_out = '0;
                phase = 0;
                idx = 0;
                started = 1'b0;
                dly = $urandom_range(0, ring_max_dly);
            end else begin
                if (ring_start) begin
                    started = 1'b1;
                end
                case (phase)
                    0: if (started && !ring_ack) begin
                        if (dly > 0) begin
                            dly--;
                        end else begin
                            ring_out = encode(fib_term(idx));
                            if (inject_illegal && idx == 1) begin
                                ring_out[3] = 2'b11;
                            end
                            t_present = cyc;
                            present_idx = idx;
                            phase = 1;
                            dly = $urandom_range(0, ring_max_dly);
                        end
                    end
                    1: if (ring_ack && !stall_null) begin
                        if (dly > 0) begin
                            dly--;
                        end else begin
                            ring_out = '0;
                            idx++;
                            phase = 2;
                        end
                    end
                    2: if (!ring_ack) begin
                        phase = 0;
                        dly = $urandom_range(0, ring_max_dly);
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (done) begin
                done_cnt++;
            end
            if (res_valid && res_ready) begin
                check("res_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_last", res_last, e.last);
                    check("res_ovf", res_ovf, e.ovf);
                end
            end
        end
    end

    task automatic issue(input int n);
        int k;
        k = 0;
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_count = CW'(n);
        push_expect(n);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("run_idle", busy, 0);
    endtask

    task automatic finish_run(input int d0, input string tag);
        wait_idle(3000);
        @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_ring_rst"}, ring_rst, 1);
    endtask

    task automatic wait_flag(input int budget, input int which);
        int k;
        k = 0;
        while (k < budget && !((which == 0 && res_valid) || (which == 1 && err_proto) ||
                               (which == 2 && err_timeout) || (which == 3 && present_idx == 2))) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before limit");
        $fatal(1);
    end

    initial begin
        int  k;
        int  d0;
        bit  ack_ok;
        bit  data_ok;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ring_rst, ring_start, ring_ack, cmd_ready, res_valid, res_last, res_ovf,
               busy, done, err_proto, err_timeout, res_data},
              {1'b1, 10'b0, {W{1'b0}}});

        rst = 1'b0;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_latency", k, RC);

        // Basic run with capture latency measured on the first term.
        d0 = done_cnt;
        issue(5);
        wait_flag(100, 0);
        check("capture_latency", cyc - t_present, SS + 2);
        check("capture_ack", ring_ack, 1);
        finish_run(d0, "basic");

        // Backpressure: hold res_ready low for 20 cycles after the first term.
        ready_mode = 2;
        d0 = done_cnt;
        issue(4);
        wait_flag(100, 0);
        check("bp_first_valid", res_valid, 1);
        ack_ok = 1'b1;
        data_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            ack_ok &= ring_ack;
            data_ok &= (res_valid && res_data == W'(1));
        end
        check("bp_ack_held", ack_ok, 1);
        check("bp_data_stable", data_ok, 1);
        ready_mode = 0;
        finish_run(d0, "backpressure");

        // Zero count.
        issue(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_once", done, 0);
        check("zero_ring_rst", ring_rst, 1);
        check("zero_no_valid", res_valid, 0);

        // Abort while idle is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ignored", {busy, cmd_ready}, 2'b01);

        // Illegal word in WAIT_DATA.
        inject_illegal = 1'b1;
        d0 = done_cnt;
        issue(4);
        wait_flag(200, 1);
        check("illegal_err_proto", err_proto, 1);
        check("illegal_idle", busy, 0);
        check("illegal_no_valid", res_valid, 0);
        repeat (3) @(negedge clk);
        check("illegal_no_done", done_cnt - d0, 0);
        exp_q.delete();
        inject_illegal = 1'b0;

        // Ring stalls with ack high.
        stall_null = 1'b1;
        d0 = done_cnt;
        issue(3);
        wait_flag(TO + 200, 2);
        check("timeout_err", err_timeout, 1);
        check("timeout_idle", busy, 0);
        check("timeout_no_done", done_cnt - d0, 0);
        exp_q.delete();
        stall_null = 1'b0;
        d0 = done_cnt;
        issue(3);
        check("timeout_cleared", {err_timeout, err_proto}, 2'b00);
        finish_run(d0, "after_timeout");

        // Eight-bit wrap: term 14 is 377 mod 256.
        d0 = done_cnt;
        issue(14);
        finish_run(d0, "wrap");
        check("wrap_ovf_sticky", res_ovf, 1);
        check("wrap_last_data", res_data, 121);

        // Abort while the third term is in CAPTURE.
        present_idx = -1;
        d0 = done_cnt;
        issue(6);
        wait_flag(300, 3);
        check("abort_reach_term", present_idx, 2);
        k = 0;
        while (cyc < t_present + 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_no_valid", res_valid, 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        exp_q.delete();

        // Randomised runs with random ring delays and random backpressure.
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            ring_max_dly = $urandom_range(0, 3);
            d0 = done_cnt;
            issue($urandom_range(1, 12));
            finish_run(d0, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
